// File: rtl/simt_warp_stack_if.sv
// rtl/simt_warp_stack_if.sv - branch/check request and response bundle for simt_warp_stack
interface simt_warp_stack_if #(
    parameter int NUM_WARPS = 4,
    parameter int WARP_SIZE = 32,
    parameter int PC_WIDTH  = 32
);
    localparam int WW = (NUM_WARPS > 1) ? $clog2(NUM_WARPS) : 1;

    logic                 br_valid;
    logic                 br_ready;
    logic [WW-1:0]        br_warp;
    logic [WARP_SIZE-1:0] br_taken;
    logic [PC_WIDTH-1:0]  br_target_pc;
    logic [PC_WIDTH-1:0]  br_fallthru_pc;
    logic [PC_WIDTH-1:0]  br_reconv_pc;

    logic                 chk_valid;
    logic                 chk_ready;
    logic [WW-1:0]        chk_warp;
    logic [PC_WIDTH-1:0]  chk_pc;

    logic                 resp_valid;
    logic [WW-1:0]        resp_warp;
    logic [PC_WIDTH-1:0]  resp_pc;
    logic                 resp_redirect;
    logic                 resp_ovf;

    modport master (
        output br_valid, br_warp, br_taken, br_target_pc, br_fallthru_pc, br_reconv_pc,
        output chk_valid, chk_warp, chk_pc,
        input  br_ready, chk_ready,
        input  resp_valid, resp_warp, resp_pc, resp_redirect, resp_ovf
    );

    modport slave (
        input  br_valid, br_warp, br_taken, br_target_pc, br_fallthru_pc, br_reconv_pc,
        input  chk_valid, chk_warp, chk_pc,
        output br_ready, chk_ready,
        output resp_valid, resp_warp, resp_pc, resp_redirect, resp_ovf
    );
endinterface

// File: rtl/simt_warp_stack.sv
// rtl/simt_warp_stack.sv - per-warp SIMT divergence/reconvergence stack (optional SIMT_WARP_STACK_OVF_ERR_EN)
module simt_warp_stack #(
    parameter int NUM_WARPS = 4,
    parameter int DEPTH     = 8,
    parameter int WARP_SIZE = 32,
    parameter int PC_WIDTH  = 32
) (
    input  logic                           clk,
    input  logic                           rst,
    simt_warp_stack_if.slave               bus,
    output logic [NUM_WARPS*WARP_SIZE-1:0] active_mask,
    output logic [NUM_WARPS-1:0]           warp_empty,
    output logic [NUM_WARPS-1:0]           warp_full,
    output logic [NUM_WARPS-1:0]           ovf_err
);
    localparam int WW = (NUM_WARPS > 1) ? $clog2(NUM_WARPS) : 1;
    localparam int DW = $clog2(DEPTH + 1);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef struct packed {
        logic [PC_WIDTH-1:0]  reconv_pc;
        logic [WARP_SIZE-1:0] reconv_mask;
        logic [PC_WIDTH-1:0]  else_pc;
        logic [WARP_SIZE-1:0] else_mask;
        logic                 else_pending;
    } entry_t;

    entry_t               stack_q [NUM_WARPS][DEPTH];
    logic [DW-1:0]        depth_q [NUM_WARPS];
    logic [WARP_SIZE-1:0] mask_q  [NUM_WARPS];

    logic                 resp_valid_q, resp_redirect_q, resp_ovf_q;
    logic [WW-1:0]        resp_warp_q;
    logic [PC_WIDTH-1:0]  resp_pc_q;
    logic                 resp_redirect_d, resp_ovf_d;
    logic [PC_WIDTH-1:0]  resp_pc_d;

    logic                 br_acc, chk_acc, op_acc;
    logic [WW-1:0]        op_warp;
    logic [WARP_SIZE-1:0] cur_mask, taken, mask_d;
    logic [DW-1:0]        cur_depth;
    logic [AW-1:0]        top_idx, push_idx;
    entry_t               top;
    logic                 is_empty, is_full, pc_match;
    logic                 mask_we, push, pop, clr_pending;

    // Branch always wins arbitration; at most one op is accepted per cycle.
    assign bus.br_ready  = 1'b1;
    assign bus.chk_ready = !bus.br_valid;
    assign br_acc        = bus.br_valid;
    assign chk_acc       = bus.chk_valid && !bus.br_valid;
    assign op_acc        = br_acc || chk_acc;

    assign op_warp   = br_acc ? bus.br_warp : bus.chk_warp;
    assign cur_mask  = mask_q[op_warp];
    assign cur_depth = depth_q[op_warp];
    assign taken     = bus.br_taken & cur_mask;
    assign top_idx   = AW'(cur_depth - DW'(1));
    assign push_idx  = AW'(cur_depth);
    assign top       = stack_q[op_warp][top_idx];
    assign is_empty  = (cur_depth == '0);
    assign is_full   = (cur_depth == DW'(DEPTH));
    assign pc_match  = (bus.chk_pc == top.reconv_pc);

    // Decide the stack action and response for the single accepted op.
    always_comb begin
        mask_we         = 1'b0;
        mask_d          = cur_mask;
        push            = 1'b0;
        pop             = 1'b0;
        clr_pending     = 1'b0;
        resp_pc_d       = '0;
        resp_redirect_d = 1'b0;
        resp_ovf_d      = 1'b0;
        if (br_acc) begin
            if (taken == cur_mask) begin
                resp_pc_d = bus.br_target_pc;
            end else if (taken == '0) begin
                resp_pc_d = bus.br_fallthru_pc;
            end else if (!is_full) begin
                push            = 1'b1;
                mask_we         = 1'b1;
                mask_d          = taken;
                resp_pc_d       = bus.br_target_pc;
                resp_redirect_d = 1'b1;
            end else begin
                // No room to record the divergence: keep running the whole mask down the taken path.
                resp_pc_d  = bus.br_target_pc;
                resp_ovf_d = 1'b1;
            end
        end else if (chk_acc) begin
            resp_pc_d = bus.chk_pc;
            if (!is_empty && pc_match) begin
                mask_we = 1'b1;
                if (top.else_pending) begin
                    mask_d          = top.else_mask;
                    clr_pending     = 1'b1;
                    resp_pc_d       = top.else_pc;
                    resp_redirect_d = 1'b1;
                end else begin
                    mask_d = top.reconv_mask;
                    pop    = 1'b1;
                end
            end
        end
    end

    // Entry storage; not reset because depth alone defines which entries are live.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (push) begin
                stack_q[op_warp][push_idx] <= '{reconv_pc:    bus.br_reconv_pc,
                                               reconv_mask:  cur_mask,
                                               else_pc:      bus.br_fallthru_pc,
                                               else_mask:    cur_mask & ~taken,
                                               else_pending: 1'b1};
            end
            if (clr_pending) begin
                stack_q[op_warp][top_idx].else_pending <= 1'b0;
            end
        end
    end

    // Per-warp mask/depth and the registered response.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int w = 0; w < NUM_WARPS; w++) begin
                depth_q[w] <= '0;
                mask_q[w]  <= '1;
            end
            resp_valid_q    <= 1'b0;
            resp_warp_q     <= '0;
            resp_pc_q       <= '0;
            resp_redirect_q <= 1'b0;
            resp_ovf_q      <= 1'b0;
        end else begin
            resp_valid_q    <= op_acc;
            resp_warp_q     <= op_acc ? op_warp : '0;
            resp_pc_q       <= resp_pc_d;
            resp_redirect_q <= resp_redirect_d;
            resp_ovf_q      <= resp_ovf_d;
            if (mask_we) begin
                mask_q[op_warp] <= mask_d;
            end
            if (push) begin
                depth_q[op_warp] <= cur_depth + DW'(1);
            end else if (pop) begin
                depth_q[op_warp] <= cur_depth - DW'(1);
            end
        end
    end

`ifdef SIMT_WARP_STACK_OVF_ERR_EN
    logic [NUM_WARPS-1:0] ovf_q;

    // Sticky per-warp record that a divergence was dropped for lack of space.
    always_ff @(posedge clk) begin
        if (rst) begin
            ovf_q <= '0;
        end else if (resp_ovf_d) begin
            ovf_q[op_warp] <= 1'b1;
        end
    end

    assign ovf_err = ovf_q;
`else
    assign ovf_err = '0;
`endif

    assign bus.resp_valid    = resp_valid_q;
    assign bus.resp_warp     = resp_warp_q;
    assign bus.resp_pc       = resp_pc_q;
    assign bus.resp_redirect = resp_redirect_q;
    assign bus.resp_ovf      = resp_ovf_q;

    for (genvar w = 0; w < NUM_WARPS; w++) begin : g_status
        assign active_mask[w*WARP_SIZE +: WARP_SIZE] = mask_q[w];
        assign warp_empty[w] = (depth_q[w] == '0);
        assign warp_full[w]  = (depth_q[w] == DW'(DEPTH));
    end
endmodule
